// File: rtl/carga_ventana.sv
// Per-frame window loader: copies the current image into the reference RAM, then
// refills the current RAM from the pixel stream and hands the frame to the search FSM.
module carga_ventana #(
   parameter int MSBI         = 10,
   parameter int WINDOW_DEPTH = 400
) (
   input  logic            clk_fsm,
   input  logic            reset_n,
   input  logic            sof,
   input  logic [23:0]     pix_data,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic            search_start,
   input  logic            search_finish,
   output logic [1:0]      cont_img,
   output logic [MSBI:0]   window_limit,
   output logic [MSBI:0]   add_rd_act,
   input  logic [24:0]     data_rd_act,
   output logic [MSBI:0]   add_wr_act,
   output logic [24:0]     data_wr_act,
   output logic            wr_en_act,
   output logic [MSBI:0]   add_wr_ref,
   output logic [24:0]     data_wr_ref,
   output logic            wr_en_ref,
   output logic            busy,
   output logic            frame_done,
   output logic            overrun
);

   localparam int AW = MSBI + 1;
   localparam logic [MSBI:0] DEPTH = AW'(WINDOW_DEPTH);
   localparam logic [MSBI:0] LAST  = AW'(WINDOW_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      COPY,
      LOAD,
      FIRST,
      START,
      WAIT
   } state_t;

   state_t        state;
   logic [MSBI:0] rd_addr;
   logic [MSBI:0] wr_addr;
   logic [1:0]    cont_q;
   logic          first_frame;
   logic          overrun_q;
   logic          busy_q;
   logic          ready_q;
   logic          wr_en_ref_q;
   logic          start_q;
   logic          done_q;

   // The "used" flag of the read word is deliberately discarded on copy.
   logic          unused_used_flag;
   assign unused_used_flag = data_rd_act[24];

   assign window_limit = LAST;
   assign add_rd_act   = rd_addr;
   assign add_wr_ref   = wr_addr;
   assign add_wr_act   = wr_addr;
   assign data_wr_ref  = {1'b0, data_rd_act[23:0]};
   assign data_wr_act  = {1'b0, pix_data};
   assign wr_en_ref    = wr_en_ref_q;
   assign wr_en_act    = ready_q & pix_valid;
   assign pix_ready    = ready_q;
   assign search_start = start_q;
   assign frame_done   = done_q;
   assign cont_img     = cont_q;
   assign overrun      = overrun_q;
   assign busy         = busy_q;

   always_ff @(posedge clk_fsm) begin
      if (!reset_n) begin
         state       <= IDLE;
         rd_addr     <= '0;
         wr_addr     <= '0;
         cont_q      <= 2'd0;
         first_frame <= 1'b1;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         wr_en_ref_q <= 1'b0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         wr_en_ref_q <= 1'b0;
         if (sof && state != IDLE)
            overrun_q <= 1'b1;

         case (state)
            IDLE: begin
               if (sof) begin
                  state   <= COPY;
                  rd_addr <= '0;
                  wr_addr <= '0;
                  busy_q  <= 1'b1;
               end
            end

            // Read address leads the ref write by one cycle to cover RAM latency.
            COPY: begin
               if (rd_addr != DEPTH) begin
                  rd_addr     <= rd_addr + 1'b1;
                  wr_addr     <= rd_addr;
                  wr_en_ref_q <= 1'b1;
               end else begin
                  state   <= LOAD;
                  wr_addr <= '0;
                  ready_q <= 1'b1;
               end
            end

            LOAD: begin
               if (pix_valid) begin
                  wr_addr <= wr_addr + 1'b1;
                  if (wr_addr == LAST) begin
                     ready_q <= 1'b0;
                     if (first_frame) begin
                        state  <= FIRST;
                        done_q <= 1'b1;
                     end else begin
                        state   <= START;
                        start_q <= 1'b1;
                     end
                  end
               end
            end

            // No reference exists yet on the first frame, so skip the search.
            FIRST: begin
               first_frame <= 1'b0;
               state       <= IDLE;
               busy_q      <= 1'b0;
            end

            START: begin
               state <= WAIT;
            end

            WAIT: begin
               if (search_finish) begin
                  cont_q <= cont_q + 2'd1;
                  done_q <= 1'b1;
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end

            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carga_ventana.sv
// Directed bench for carga_ventana: models both RAMs and the search FSM handshake,
// runs a table of frames and a few hand-written corner sequences.
module tb_carga_ventana;

   localparam int MSBI = 10;

   logic          clk_fsm = 1'b0;
   logic          reset_n;
   logic          sof;
   logic [23:0]   pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          search_start;
   logic          search_finish;
   logic [1:0]    cont_img;
   logic [MSBI:0] window_limit;
   logic [MSBI:0] add_rd_act;
   logic [24:0]   data_rd_act;
   logic [MSBI:0] add_wr_act;
   logic [24:0]   data_wr_act;
   logic          wr_en_act;
   logic [MSBI:0] add_wr_ref;
   logic [24:0]   data_wr_ref;
   logic          wr_en_ref;
   logic          busy;
   logic          frame_done;
   logic          overrun;

   carga_ventana #(.MSBI(MSBI), .WINDOW_DEPTH(400)) dut (
      .clk_fsm(clk_fsm), .reset_n(reset_n), .sof(sof), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .search_start(search_start),
      .search_finish(search_finish), .cont_img(cont_img), .window_limit(window_limit),
      .add_rd_act(add_rd_act), .data_rd_act(data_rd_act), .add_wr_act(add_wr_act),
      .data_wr_act(data_wr_act), .wr_en_act(wr_en_act), .add_wr_ref(add_wr_ref),
      .data_wr_ref(data_wr_ref), .wr_en_ref(wr_en_ref), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk_fsm = ~clk_fsm;

   // RAM models (port B side), filled with a known pattern with bit 24 set.
   logic [24:0] act_ram [0:2047];
   logic [24:0] ref_ram [0:2047];
   logic        ram_init;
   logic [10:0] init_ptr = '0;

   always @(posedge clk_fsm) begin
      if (ram_init) begin
         act_ram[init_ptr] <= {1'b1, 24'hA50000 ^ {13'd0, init_ptr}};
         ref_ram[init_ptr] <= 25'h1FFFFFF;
         init_ptr          <= init_ptr + 11'd1;
      end else begin
         if (wr_en_act) act_ram[add_wr_act] <= data_wr_act;
         if (wr_en_ref) ref_ram[add_wr_ref] <= data_wr_ref;
      end
      data_rd_act <= act_ram[add_rd_act];
   end

   int cnt_ref = 0, cnt_act = 0, cnt_start = 0, cnt_done = 0, cnt_both = 0;
   always @(negedge clk_fsm) begin
      if (wr_en_ref) cnt_ref <= cnt_ref + 1;
      if (wr_en_act) cnt_act <= cnt_act + 1;
      if (search_start) cnt_start <= cnt_start + 1;
      if (frame_done) cnt_done <= cnt_done + 1;
      if (wr_en_ref && wr_en_act) cnt_both <= cnt_both + 1;
   end

   typedef struct {
      bit          first;
      bit          gap;
      logic [23:0] base;
      int          fin_delay;
      bit          sof_wait;
      bit          chk_ref;
      logic [1:0]  exp_cont;
      bit          exp_ovr;
      int          exp_load;
      int          exp_start;
   } vec_t;

   vec_t        tbl [0:6];
   logic [24:0] exp_act [0:2047];
   int          checks = 0;
   int          errors = 0;
   int          cur_frame = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s frame=%0d actual=%0h required=%0h", nm, cur_frame, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int n, cyc, k, r0, a0, s0, d0;
      logic [24:0] prev [0:399];
      r0 = cnt_ref; a0 = cnt_act; s0 = cnt_start; d0 = cnt_done;
      for (int i = 0; i < 400; i++) prev[i] = exp_act[i];
      sof = 1'b1;
      @(negedge clk_fsm);
      sof = 1'b0;
      n = 0;
      while (!pix_ready && n < 1000) begin
         @(negedge clk_fsm);
         n++;
      end
      chk("copy_cycles", n, 401);
      cyc = 0; k = 0;
      while (pix_ready && cyc < 2000) begin
         pix_valid = v.gap ? cyc[0] : 1'b1;
         pix_data  = v.base + 24'(k);
         if (pix_valid) k++;
         cyc++;
         @(negedge clk_fsm);
      end
      pix_valid = 1'b0;
      chk("load_cycles", cyc, v.exp_load);
      chk("load_words", k, 400);
      if (!v.first) begin
         n = 0;
         while (!search_start && n < 10) begin
            @(negedge clk_fsm);
            n++;
         end
         chk("start_seen", search_start, 1);
         for (int d = 0; d < v.fin_delay; d++) begin
            sof = (v.sof_wait && d == 10);
            @(negedge clk_fsm);
         end
         sof = 1'b0;
         search_finish = 1'b1;
         @(negedge clk_fsm);
         search_finish = 1'b0;
      end
      repeat (3) @(negedge clk_fsm);
      chk("ref_writes", cnt_ref - r0, 400);
      chk("act_writes", cnt_act - a0, 400);
      chk("start_pulses", cnt_start - s0, v.exp_start);
      chk("frame_done", cnt_done - d0, 1);
      chk("cont_img", cont_img, v.exp_cont);
      chk("overrun", overrun, v.exp_ovr);
      chk("busy_after", busy, 0);
      for (int i = 0; i < 400; i++) begin
         exp_act[i] = {1'b0, v.base + 24'(i)};
         if (v.chk_ref) chk("ref_data", ref_ram[i], {1'b0, prev[i][23:0]});
         chk("act_data", act_ram[i], exp_act[i]);
      end
      chk("act_guard", act_ram[400], {1'b1, 24'hA50000 ^ 24'd400});
      chk("ref_guard", ref_ram[400], 25'h1FFFFFF);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int a0, n;
      //          first gap base       dly sofw chk cont ovr load start
      tbl[0] = '{1'b1, 1'b0, 24'h000001,  0, 1'b0, 1'b1, 2'd0, 1'b0, 400, 0};
      tbl[1] = '{1'b0, 1'b0, 24'h100000, 50, 1'b0, 1'b1, 2'd1, 1'b0, 400, 1};
      tbl[2] = '{1'b0, 1'b1, 24'h200000, 20, 1'b0, 1'b1, 2'd2, 1'b0, 800, 1};
      tbl[3] = '{1'b0, 1'b0, 24'h300000, 30, 1'b1, 1'b1, 2'd3, 1'b1, 400, 1};
      tbl[4] = '{1'b0, 1'b0, 24'h400000,  5, 1'b0, 1'b1, 2'd0, 1'b1, 400, 1};
      tbl[5] = '{1'b0, 1'b0, 24'h500000,  5, 1'b0, 1'b1, 2'd1, 1'b1, 400, 1};
      tbl[6] = '{1'b1, 1'b0, 24'h600000,  0, 1'b0, 1'b0, 2'd0, 1'b0, 400, 0};
      for (int i = 0; i < 2048; i++) exp_act[i] = {1'b1, 24'hA50000 ^ 24'(i)};

      reset_n = 1'b0; sof = 1'b0; pix_valid = 1'b1; pix_data = 24'h123456;
      search_finish = 1'b0; ram_init = 1'b1;
      repeat (2050) @(negedge clk_fsm);
      ram_init = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_ready", pix_ready, 0);
      chk("rst_cont", cont_img, 0);
      chk("rst_limit", window_limit, 399);
      chk("rst_wr_act", wr_en_act, 0);
      chk("rst_wr_ref", wr_en_ref, 0);
      chk("rst_start", search_start, 0);
      chk("rst_overrun", overrun, 0);

      // Words offered while idle must not be consumed.
      a0 = cnt_act;
      reset_n = 1'b1;
      repeat (5) @(negedge clk_fsm);
      chk("idle_no_ready", pix_ready, 0);
      chk("idle_no_write", cnt_act - a0, 0);
      pix_valid = 1'b0;

      for (int f = 0; f < 6; f++) begin
         cur_frame = f;
         run_frame(tbl[f]);
      end

      // Reset in the middle of LOAD, then a fresh first frame.
      cur_frame = 100;
      sof = 1'b1;
      @(negedge clk_fsm);
      sof = 1'b0;
      n = 0;
      while (!pix_ready && n < 1000) begin
         @(negedge clk_fsm);
         n++;
      end
      chk("t6_load_entered", pix_ready, 1);
      for (int k = 0; k < 200; k++) begin
         pix_valid = 1'b1;
         pix_data  = 24'h700000 + 24'(k);
         @(negedge clk_fsm);
      end
      pix_valid = 1'b0;
      chk("t6_busy_before", busy, 1);
      reset_n = 1'b0;
      @(negedge clk_fsm);
      chk("t6_busy", busy, 0);
      chk("t6_ready", pix_ready, 0);
      chk("t6_overrun", overrun, 0);
      chk("t6_cont", cont_img, 0);
      reset_n = 1'b1;
      @(negedge clk_fsm);
      for (int i = 0; i < 200; i++) exp_act[i] = {1'b0, 24'h700000 + 24'(i)};
      cur_frame = 6;
      run_frame(tbl[6]);

      chk("never_both_wr", cnt_both, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
